// File: rtl/dmem_port_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_port_ctrl
//
// LSU-side front-end for one port of a byte-write true-dual-port data RAM.
// A byte/half/word request is taken on a valid/ready channel, translated into
// a RAM word address, byte-lane write enables and lane-replicated write data,
// and answered on a registered valid/ready response channel. Load data is
// captured one cycle after the RAM read, shifted down to bit 0 and sign- or
// zero-extended. Only one request is outstanding at a time. Misaligned or
// illegal-size requests never touch the RAM and come back with rsp_err_o set.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The request side may change its payload
// freely while req_ready_o is 0. Once rsp_valid_o is raised, the response
// payload (rsp_rdata_o, rsp_err_o) holds steady until the edge where
// rsp_ready_i is seen high.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req_valid_i      request valid
//   req_ready_o      high only in IDLE (comes from the state register)
//   req_we_i         1 = store, 0 = load
//   req_size_i       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i   load zero-extends when 1, sign-extends when 0
//   req_addr_i       byte address, AddrWidth+2 bits
//   req_wdata_i      store data, right-aligned
//   rsp_valid_o      response valid (registered)
//   rsp_ready_i      response consumed
//   rsp_rdata_o      formatted load data; 0 for stores and errors
//   rsp_err_o        misaligned or illegal-size request
//   ram_ena_o        RAM port enable, only in the accept cycle
//   ram_we_o         RAM byte-lane write enables
//   ram_addr_o       RAM word address
//   ram_din_o        RAM write data
//   ram_dout_i       RAM read data, valid the cycle after the read edge
//   dbgState         current FSM state (0 IDLE, 1 RD, 2 RESP)
// -----------------------------------------------------------------------------
module dmem_port_ctrl #(
  parameter int AddrWidth = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [AddrWidth+1:0] req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 ram_ena_o,
  output logic [3:0]           ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [31:0]          ram_din_o,
  input  logic [31:0]          ram_dout_i,
  output logic [1:0]           dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  state_t      state;
  logic [1:0]  offReg;
  logic [1:0]  sizeReg;
  logic        unsReg;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;

  logic        accept;
  logic        reqErr;
  logic        ramGo;
  logic [3:0]  laneMask;
  logic [31:0] laneData;
  logic [31:0] shifted;
  logic [31:0] loadData;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i & req_ready_o;

  // Alignment/size check. A word must sit on a 4-byte boundary, a half on a
  // 2-byte boundary; size 11 is never legal.
  always_comb begin
    reqErr = 1'b0;
    case (req_size_i)
      SizeByte: reqErr = 1'b0;
      SizeHalf: reqErr = req_addr_i[0];
      SizeWord: reqErr = (req_addr_i[1:0] != 2'b00);
      default:  reqErr = 1'b1;
    endcase
  end

  // Store lane enables and replicated data. Replication lets the same data
  // bus serve every legal offset; the enables pick the lanes actually written.
  always_comb begin
    laneMask = 4'b0000;
    laneData = req_wdata_i;
    case (req_size_i)
      SizeByte: begin
        laneMask = 4'b0001 << req_addr_i[1:0];
        laneData = {4{req_wdata_i[7:0]}};
      end
      SizeHalf: begin
        laneMask = 4'b0011 << req_addr_i[1:0];
        laneData = {2{req_wdata_i[15:0]}};
      end
      default: begin
        laneMask = 4'b1111;
        laneData = req_wdata_i;
      end
    endcase
  end

  // The RAM is driven straight from the request, only in the accept cycle.
  // rst gates it because the state register already reads IDLE during reset,
  // which would otherwise let a request through.
  assign ramGo      = accept & ~reqErr & ~rst;
  assign ram_ena_o  = ramGo;
  assign ram_we_o   = (ramGo & req_we_i) ? laneMask : 4'b0000;
  assign ram_addr_o = req_addr_i[AddrWidth+1:2];
  assign ram_din_o  = laneData;

  // Load formatting from the offset/size latched at accept.
  assign shifted = ram_dout_i >> {offReg, 3'b000};

  always_comb begin
    loadData = ram_dout_i;
    case (sizeReg)
      SizeByte: loadData = {{24{~unsReg & shifted[7]}}, shifted[7:0]};
      SizeHalf: loadData = {{16{~unsReg & shifted[15]}}, shifted[15:0]};
      default:  loadData = ram_dout_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      offReg   <= 2'b00;
      sizeReg  <= 2'b00;
      unsReg   <= 1'b0;
      rspValid <= 1'b0;
      rspData  <= 32'h0;
      rspErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (reqErr) begin
              rspErr   <= 1'b1;
              rspData  <= 32'h0;
              rspValid <= 1'b1;
              state    <= RESP;
            end else if (req_we_i) begin
              rspErr   <= 1'b0;
              rspData  <= 32'h0;
              rspValid <= 1'b1;
              state    <= RESP;
            end else begin
              offReg  <= req_addr_i[1:0];
              sizeReg <= req_size_i;
              unsReg  <= req_unsigned_i;
              state   <= RD;
            end
          end
        end
        RD: begin
          rspData  <= loadData;
          rspErr   <= 1'b0;
          rspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          rspValid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rspValid;
  assign rsp_rdata_o = rspData;
  assign rsp_err_o   = rspErr;
  assign dbgState    = state;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
module tb_dmem_port_ctrl;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [AW+1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          ram_ena_o;
  logic [3:0]    ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_din_o;
  logic [31:0]   ram_dout_i;
  logic [1:0]    dbgState;

  int nChecks = 0;
  int nPass   = 0;

  dmem_port_ctrl #(.AddrWidth(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .ram_ena_o(ram_ena_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o),
    .ram_dout_i(ram_dout_i), .dbgState(dbgState)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural byte-write RAM, one-cycle read latency.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_ena_o) begin
      for (int i = 0; i < 4; i++)
        if (ram_we_o[i]) mem[ram_addr_o][8*i +: 8] <= ram_din_o[8*i +: 8];
      ram_dout_i <= mem[ram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [AW+1:0] addr, input logic [31:0] wdata);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
  endtask

  task automatic do_store(input logic [1:0] size, input logic [AW+1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] expWe,
                          input logic [31:0] expDin);
    @(negedge clk);
    drive_req(1'b1, size, 1'b0, addr, wdata);
    #1;
    check("st_ready", 32'(req_ready_o), 32'd1);
    check("st_ena", 32'(ram_ena_o), 32'd1);
    check("st_we", 32'(ram_we_o), 32'(expWe));
    check("st_addr", 32'(ram_addr_o), 32'(addr >> 2));
    check("st_din", ram_din_o, expDin);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("st_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("st_rsp_err", 32'(rsp_err_o), 32'd0);
    check("st_rsp_rdata", rsp_rdata_o, 32'h0);
    check("st_ena_off", 32'(ram_ena_o), 32'd0);
    @(posedge clk); #1;
    check("st_back_idle", 32'(req_ready_o), 32'd1);
  endtask

  task automatic do_load(input logic [1:0] size, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] expData);
    @(negedge clk);
    drive_req(1'b0, size, uns, addr, 32'h0);
    #1;
    check("ld_ena", 32'(ram_ena_o), 32'd1);
    check("ld_we", 32'(ram_we_o), 32'd0);
    check("ld_addr", 32'(ram_addr_o), 32'(addr >> 2));
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("ld_rd_state", 32'(dbgState), 32'd1);
    check("ld_rd_valid", 32'(rsp_valid_o), 32'd0);
    check("ld_rd_ready", 32'(req_ready_o), 32'd0);
    check("ld_rd_ena", 32'(ram_ena_o), 32'd0);
    @(posedge clk); #1;
    check("ld_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("ld_rsp_err", 32'(rsp_err_o), 32'd0);
    check("ld_rsp_rdata", rsp_rdata_o, expData);
    check("ld_resp_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    check("ld_back_idle", 32'(req_ready_o), 32'd1);
  endtask

  task automatic do_err(input logic we, input logic [1:0] size, input logic [AW+1:0] addr);
    @(negedge clk);
    drive_req(we, size, 1'b0, addr, 32'h1234_5678);
    #1;
    check("err_ena", 32'(ram_ena_o), 32'd0);
    check("err_we", 32'(ram_we_o), 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("err_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("err_rsp_err", 32'(rsp_err_o), 32'd1);
    check("err_rsp_rdata", rsp_rdata_o, 32'h0);
    @(posedge clk); #1;
    check("err_back_idle", 32'(req_ready_o), 32'd1);
  endtask

  logic [31:0] heldData;

  initial begin
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_size_i = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i = '0;
    req_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    #1;
    check("rst_ena_forced", 32'(ram_ena_o), 32'd0);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'h0);
    check("rst_err", 32'(rsp_err_o), 32'd0);
    check("rst_state", 32'(dbgState), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);

    // Word 0xDEADBEEF at 0x10, then byte 0x80 at 0x11 -> mem[4]=0xDEAD80EF
    do_store(2'b10, 12'h010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_store(2'b00, 12'h011, 32'h0000_0080, 4'b0010, 32'h80808080);
    do_load(2'b00, 1'b0, 12'h011, 32'hFFFFFF80);
    do_load(2'b00, 1'b1, 12'h011, 32'h00000080);
    do_load(2'b00, 1'b0, 12'h010, 32'hFFFFFFEF);
    // Half 0x8001 at 0x12 -> mem[4]=0x800180EF
    do_store(2'b01, 12'h012, 32'h0000_8001, 4'b1100, 32'h80018001);
    do_load(2'b01, 1'b0, 12'h012, 32'hFFFF8001);
    do_load(2'b01, 1'b1, 12'h012, 32'h00008001);
    do_load(2'b00, 1'b1, 12'h013, 32'h00000080);
    do_load(2'b10, 1'b0, 12'h010, 32'h800180EF);

    // Rejected requests; the misaligned store must leave memory unchanged
    do_err(1'b0, 2'b01, 12'h013);
    do_err(1'b0, 2'b10, 12'h00E);
    do_err(1'b0, 2'b11, 12'h010);
    do_err(1'b1, 2'b01, 12'h011);
    do_load(2'b10, 1'b0, 12'h010, 32'h800180EF);

    // Stalled response
    rsp_ready_i = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    heldData = rsp_rdata_o;
    check("stall_first", rsp_rdata_o, 32'hFFFF8001);
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid_o), 32'd1);
      check("stall_rdata", rsp_rdata_o, heldData);
      check("stall_ready", 32'(req_ready_o), 32'd0);
      check("stall_ena", 32'(ram_ena_o), 32'd0);
    end
    req_valid_i = 1'b0;
    @(negedge clk);
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    check("stall_release_ready", 32'(req_ready_o), 32'd1);
    check("stall_release_valid", 32'(rsp_valid_o), 32'd0);

    // Asynchronous reset while in RD
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    @(posedge clk); #1;
    check("arst_in_rd", 32'(dbgState), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(rsp_valid_o), 32'd0);
    check("arst_ena", 32'(ram_ena_o), 32'd0);
    check("arst_state", 32'(dbgState), 32'd0);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
    do_load(2'b01, 1'b0, 12'h012, 32'hFFFF8001);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/dmem_port_ctrl.md
# dmem_port_ctrl

Load/store front-end that drives a single port of the byte-write true-dual-port data RAM on behalf of the core's LSU. It accepts byte/half/word requests on a valid/ready channel and converts them into word address, byte-lane write enables and lane-replicated write data. It captures the RAM's one-cycle read data and returns it extracted and sign- or zero-extended on a registered valid/ready response channel. One request is in flight at a time; misaligned or illegal-size requests are rejected without touching the RAM.

## Interface
- AddrWidth, 10, RAM word-address width; the request byte address is AddrWidth+2 bits
- Data path is fixed at 32 bits: 4 columns of 8 bits, column i = bits [8i+7:8i]

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- req_addr_i  in  AddrWidth+2  byte address
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  response valid (registered)
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  32  formatted load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal-size request
- ram_ena_o  out  1  RAM port enable
- ram_we_o  out  4  RAM byte-lane write enables
- ram_addr_o  out  AddrWidth  RAM word address = req_addr_i[AddrWidth+1:2]
- ram_din_o  out  32  RAM write data
- ram_dout_i  in  32  RAM read data; valid the cycle after a read-enabled edge

## Operation
- FSM states: IDLE, RD, RESP. Reset state IDLE.
- IDLE: req_ready_o=1. On accept:
  - error = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0). If error, no RAM access; load rsp_err=1 and rsp_rdata=0; go to RESP.
  - If store, ram_ena_o=1 with lanes set, rsp_rdata=0 and rsp_err=0 registered; go to RESP.
  - If load, ram_ena_o=1 and ram_we_o=0; register off=addr[1:0], size and unsigned; go to RD.
- RAM drive is combinational from the request and active only on the accept cycle. Otherwise ram_ena_o=0, ram_we_o=0, ram_addr_o/ram_din_o don't-care.
- Store lanes:
  - byte: we=0001<<off, din={4{wdata[7:0]}}
  - half: we=0011<<off, din={2{wdata[15:0]}}
  - word: we=1111, din=wdata
- RD: req_ready_o=0. Compute s=ram_dout_i>>(8*off).
  - byte: rdata = {24{~unsigned & s[7]}, s[7:0]}
  - half: rdata = {16{~unsigned & s[15]}, s[15:0]}
  - word: rdata = ram_dout_i
  - Register rdata with err=0; go to RESP.
- RESP: rsp_valid_o=1, req_ready_o=0. Response outputs are held stable until rsp_ready_i=1, then go to IDLE. A stalled response does not disturb the RAM.

## Timing
- Reset values: rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, state IDLE. ram_ena_o and ram_we_o are forced 0 while rst=1.
- Load: accept at edge N, RAM read at edge N, data registered at N+1, rsp_valid_o high after N+1. Minimum 2 cycles request-to-response.
- Store and error: rsp_valid_o high after edge N, 1 cycle.
- Throughput: one request per 3 cycles for loads and 2 cycles for stores, with rsp_ready_i held 1.
- req_ready_o is 0 in RD and RESP. There is no combinational path from rsp_ready_i to req_ready_o.
- Reset mid-operation returns the FSM to IDLE and drops any pending response. A store already committed at the accept edge is not undone.
- The other RAM port may write the same word. The read returns the RAM's value with no coherence guarantee.

## Test plan
- Store word 0xDEADBEEF at addr 0x10 -> ram_we_o=1111, ram_addr_o=4, ram_din_o=0xDEADBEEF on the accept cycle. After 1 cycle, rsp_valid_o=1, rsp_err_o=0.
- Byte stores 0x80 at 0x11 -> we=0010, din=0x80808080. Signed byte load of 0x11 -> 0xFFFFFF80; unsigned byte load -> 0x00000080.
- Half store 0x8001 at 0x12 -> we=1100, din=0x80018001. Signed half load of 0x12 -> 0xFFFF8001; rsp_valid_o rises 2 cycles after accept.
- Half load at 0x13, word load at 0x0E, size 11 at 0x10 -> each gives ram_ena_o=0, rsp_err_o=1, rsp_rdata_o=0.
- Hold rsp_ready_i=0 for 5 cycles after a load -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0. Releasing rsp_ready_i returns req_ready_o=1 the next cycle.
- Assert rst asynchronously while in RD -> rsp_valid_o=0 and ram_ena_o=0 immediately. After release, a new load completes normally.
